// File: rtl/com_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : com_tx_sched
// Brief    : Packet scheduler for a tx engine: handshake responses, a
//            three-step config sequence and toggled data packets.
// Revision : 1.0 - initial release
// ============================================================================
module com_tx_sched #(
    parameter int TMO_CYC = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       resp_req,
    input  logic [1:0] resp_type,
    input  logic       cfg_req,
    input  logic       data_req,
    input  logic       tog_clr,
    output logic       tx_fs,
    input  logic       tx_fd,
    output logic [3:0] tx_btype,
    output logic       resp_done,
    output logic       cfg_done,
    output logic       data_done,
    output logic       busy,
    output logic       err
);

    localparam int                 c_TMO_W    = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TMO_CYC - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
    localparam logic [1:0]         c_IDX_LAST = 2'd2;
    localparam logic [3:0]         c_BT_DATA0 = 4'b1101;
    localparam logic [3:0]         c_BT_DATA1 = 4'b1110;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_HOLD = 3'd3,
        S_NEXT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        K_RESP = 2'd0,
        K_CFG  = 2'd1,
        K_DATA = 2'd2
    } kind_t;

    state_t             r_state;
    state_t             w_state_nxt;
    kind_t              r_kind;
    kind_t              w_kind_nxt;
    logic               r_pend;
    logic [1:0]         r_rtype;
    logic               r_cfg_act;
    logic               w_cfg_act_nxt;
    logic [1:0]         r_cfg_idx;
    logic [1:0]         w_cfg_idx_nxt;
    logic               r_tog;
    logic               w_tog_nxt;
    logic [c_TMO_W-1:0] r_tmo;
    logic [3:0]         r_btype;
    logic [3:0]         w_btype_sel;
    logic               r_fs;
    logic               r_err;
    logic               w_load;
    logic               w_abort;
    logic               w_tmo_clr;
    logic               w_tmo_inc;
    logic               w_tmo_hit;
    logic               w_in_next;
    logic               w_cfg_more;

    always_comb begin
        w_state_nxt = r_state;
        w_kind_nxt  = r_kind;
        w_load      = 1'b0;
        w_abort     = 1'b0;
        w_tmo_clr   = 1'b0;
        w_tmo_inc   = 1'b0;
        w_tmo_hit   = (r_tmo == c_TMO_LAST);
        w_in_next   = (r_state == S_NEXT);
        // The sequence still owes packets unless this NEXT closes out DDIDX
        w_cfg_more  = r_cfg_act && !((r_kind == K_CFG) && (r_cfg_idx == c_IDX_LAST));

        case (r_state)
            S_IDLE: begin
                if (r_pend) begin
                    w_load      = 1'b1;
                    w_kind_nxt  = K_RESP;
                    w_state_nxt = S_LOAD;
                end else if (cfg_req) begin
                    w_load      = 1'b1;
                    w_kind_nxt  = K_CFG;
                    w_state_nxt = S_LOAD;
                end else if (data_req) begin
                    w_load      = 1'b1;
                    w_kind_nxt  = K_DATA;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_tmo_clr   = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (tx_fd) begin
                    w_tmo_clr   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_inc   = 1'b1;
                end
            end
            S_HOLD: begin
                if (!tx_fd) begin
                    w_state_nxt = S_NEXT;
                end else if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_inc   = 1'b1;
                end
            end
            S_NEXT: begin
                if (w_cfg_more) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_LOAD;
                    // A waiting response slips in between config packets
                    w_kind_nxt  = (r_pend && (r_kind != K_RESP)) ? K_RESP : K_CFG;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_cfg_idx_nxt = r_cfg_idx;
        w_cfg_act_nxt = r_cfg_act;
        w_tog_nxt     = r_tog;
        if (w_in_next && (r_kind == K_CFG)) begin
            if (r_cfg_idx == c_IDX_LAST) begin
                w_cfg_idx_nxt = 2'd0;
                w_cfg_act_nxt = 1'b0;
            end else begin
                w_cfg_idx_nxt = r_cfg_idx + 2'd1;
            end
        end
        if (w_in_next && (r_kind == K_DATA)) begin
            w_tog_nxt = !r_tog;
        end
        if (tog_clr) begin
            w_tog_nxt = 1'b0;
        end
        if (w_abort) begin
            w_cfg_idx_nxt = 2'd0;
            w_cfg_act_nxt = 1'b0;
        end
        if (w_load && (w_kind_nxt == K_CFG)) begin
            w_cfg_act_nxt = 1'b1;
        end

        // Config types are 0101/0110/0111 for index 0/1/2
        case (w_kind_nxt)
            K_RESP:  w_btype_sel = {2'b00, r_rtype};
            K_CFG:   w_btype_sel = {2'b01, w_cfg_idx_nxt + 2'd1};
            K_DATA:  w_btype_sel = w_tog_nxt ? c_BT_DATA1 : c_BT_DATA0;
            default: w_btype_sel = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_kind    <= K_RESP;
            r_pend    <= 1'b0;
            r_rtype   <= 2'b00;
            r_cfg_act <= 1'b0;
            r_cfg_idx <= 2'd0;
            r_tog     <= 1'b0;
            r_tmo     <= '0;
            r_btype   <= 4'b0000;
            r_fs      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cfg_act <= w_cfg_act_nxt;
            r_cfg_idx <= w_cfg_idx_nxt;
            r_tog     <= w_tog_nxt;
            r_fs      <= (w_state_nxt == S_SEND);
            r_err     <= w_abort;
            if (w_load) begin
                r_kind <= w_kind_nxt;
            end
            // A fresh request wins over the clear of the one just completed
            if (resp_req && (resp_type != 2'b00)) begin
                r_pend  <= 1'b1;
                r_rtype <= resp_type;
            end else if (w_in_next && (r_kind == K_RESP)) begin
                r_pend  <= 1'b0;
            end
            if (w_tmo_clr || w_abort) begin
                r_tmo <= '0;
            end else if (w_tmo_inc) begin
                r_tmo <= r_tmo + c_TMO_ONE;
            end
            if (w_load) begin
                r_btype <= w_btype_sel;
            end else if (w_state_nxt == S_IDLE) begin
                r_btype <= 4'b0000;
            end
        end
    end

    assign tx_fs     = r_fs;
    assign tx_btype  = r_btype;
    assign err       = r_err;
    assign busy      = (r_state != S_IDLE);
    assign resp_done = w_in_next && (r_kind == K_RESP);
    assign data_done = w_in_next && (r_kind == K_DATA);
    assign cfg_done  = w_in_next && (r_kind == K_CFG) && (r_cfg_idx == c_IDX_LAST);

endmodule
`default_nettype wire

// File: tb/tb_com_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_com_tx_sched
// Brief    : Self-checking bench for com_tx_sched with a tx engine responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_com_tx_sched;

    localparam int TMO = 16;
    localparam int OP_RESP = 0, OP_DATA = 1, OP_CFG = 2, OP_CLRDATA = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       resp_req, cfg_req, data_req, tog_clr, tx_fd;
    logic [1:0] resp_type;
    logic       tx_fs, resp_done, cfg_done, data_done, busy, err;
    logic [3:0] tx_btype;

    int n_tests = 0, n_fail = 0;
    int rd_cnt = 0, cd_cnt = 0, dd_cnt = 0, err_cnt = 0;
    int fd_dly = 3;
    bit fd_hang = 1'b0, fd_stick = 1'b0;
    logic [3:0] exp_q[$];

    typedef struct {
        int         op;
        logic [1:0] rtype;
        int         npkt;
        logic [11:0] bts;
        int         rd, cd, dd;
    } vec_t;
    vec_t vecs[10];

    com_tx_sched #(.TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .resp_req(resp_req), .resp_type(resp_type),
        .cfg_req(cfg_req), .data_req(data_req), .tog_clr(tog_clr),
        .tx_fs(tx_fs), .tx_fd(tx_fd), .tx_btype(tx_btype),
        .resp_done(resp_done), .cfg_done(cfg_done), .data_done(data_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // tx engine: raise fd fd_dly cycles after fs, drop it once fs falls
    initial begin
        int eng_cnt;
        eng_cnt = 0;
        tx_fd = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                tx_fd = 1'b0;
                eng_cnt = 0;
            end else if (tx_fs) begin
                if (!fd_hang) begin
                    eng_cnt++;
                    if (eng_cnt >= fd_dly) tx_fd = 1'b1;
                end
            end else if (!fd_stick) begin
                tx_fd = 1'b0;
                eng_cnt = 0;
            end
        end
    end

    // Scoreboard: each new packet start pops the expected type
    initial begin
        logic prev_fs;
        prev_fs = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_fs && !prev_fs) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pkt_unexpected: got btype %b, required no packet", tx_btype);
                end else begin
                    check("pkt_btype", tx_btype, exp_q.pop_front());
                end
            end
            prev_fs = tx_fs;
            if (rst) begin
                rd_cnt += resp_done;
                cd_cnt += cfg_done;
                dd_cnt += data_done;
                err_cnt += err;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_busy(input string nm);
        int i = 0;
        while (!busy && i < 200) begin @(negedge clk); i++; end
        check(nm, busy, 1);
    endtask

    task automatic wait_idle(input string nm);
        int i = 0;
        while (busy && i < 500) begin @(negedge clk); i++; end
        check(nm, busy, 0);
    endtask

    task automatic pulse_resp(input logic [1:0] t);
        resp_req = 1'b1;
        resp_type = t;
        @(negedge clk);
        resp_req = 1'b0;
        resp_type = 2'b00;
    endtask

    task automatic run_data();
        data_req = 1'b1;
        wait_busy("data_start");
        data_req = 1'b0;
        wait_idle("data_end");
    endtask

    initial begin
        int rd0, cd0, dd0, e0, n, i;
        bit busy_seen;

        vecs[0] = '{OP_RESP,    2'b01, 1, 12'h001, 1, 0, 0};
        vecs[1] = '{OP_RESP,    2'b11, 1, 12'h003, 1, 0, 0};
        vecs[2] = '{OP_RESP,    2'b00, 0, 12'h000, 0, 0, 0};
        vecs[3] = '{OP_DATA,    2'b00, 1, 12'h00D, 0, 0, 1};
        vecs[4] = '{OP_DATA,    2'b00, 1, 12'h00E, 0, 0, 1};
        vecs[5] = '{OP_DATA,    2'b00, 1, 12'h00D, 0, 0, 1};
        vecs[6] = '{OP_CLRDATA, 2'b00, 1, 12'h00D, 0, 0, 1};
        vecs[7] = '{OP_CFG,     2'b00, 3, 12'h765, 0, 1, 0};
        vecs[8] = '{OP_DATA,    2'b00, 1, 12'h00E, 0, 0, 1};
        vecs[9] = '{OP_RESP,    2'b10, 1, 12'h002, 1, 0, 0};

        rst = 1'b0;
        resp_req = 1'b0; resp_type = 2'b00; cfg_req = 1'b0; data_req = 1'b0; tog_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_fs", tx_fs, 0);
        check("rst_btype", tx_btype, 0);
        check("rst_busy", busy, 0);
        check("rst_done_err", {resp_done, cfg_done, data_done, err}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Response latency: flag at edge k, type after k+1, fs after k+2
        rd0 = rd_cnt;
        exp_q.push_back(4'b0010);
        pulse_resp(2'b10);
        check("lat_k_btype", tx_btype, 0);
        check("lat_k_busy", busy, 0);
        @(negedge clk);
        check("lat_k1_btype", tx_btype, 4'b0010);
        check("lat_k1_fs", tx_fs, 0);
        @(negedge clk);
        check("lat_k2_fs", tx_fs, 1);
        wait_idle("lat_idle");
        check("lat_idle_btype", tx_btype, 0);
        check("lat_resp_done", rd_cnt - rd0, 1);

        for (int v = 0; v < 10; v++) begin
            rd0 = rd_cnt; cd0 = cd_cnt; dd0 = dd_cnt;
            for (int p = 0; p < vecs[v].npkt; p++) exp_q.push_back(vecs[v].bts[p*4 +: 4]);
            case (vecs[v].op)
                OP_RESP: begin
                    pulse_resp(vecs[v].rtype);
                    if (vecs[v].npkt > 0) begin
                        wait_busy("vec_resp_start");
                        wait_idle("vec_resp_end");
                    end else begin
                        busy_seen = 1'b0;
                        repeat (6) begin @(negedge clk); busy_seen |= busy; end
                        check("vec_type00_ignored", busy_seen, 0);
                    end
                end
                OP_CFG: begin
                    cfg_req = 1'b1;
                    wait_busy("vec_cfg_start");
                    cfg_req = 1'b0;
                    wait_idle("vec_cfg_end");
                end
                OP_CLRDATA: begin
                    tog_clr = 1'b1;
                    @(negedge clk);
                    tog_clr = 1'b0;
                    run_data();
                end
                default: run_data();
            endcase
            check("vec_q_empty", exp_q.size(), 0);
            check("vec_resp_done", rd_cnt - rd0, vecs[v].rd);
            check("vec_cfg_done", cd_cnt - cd0, vecs[v].cd);
            check("vec_data_done", dd_cnt - dd0, vecs[v].dd);
        end

        // Response arriving during DPARAM is inserted before DDIDX
        rd0 = rd_cnt; cd0 = cd_cnt;
        exp_q.push_back(4'b0101); exp_q.push_back(4'b0110);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0111);
        cfg_req = 1'b1;
        i = 0;
        while (!(tx_fs && tx_btype == 4'b0110) && i < 200) begin @(negedge clk); i++; end
        check("pre_dparam_send", {tx_fs, tx_btype}, 5'b10110);
        pulse_resp(2'b01);
        cfg_req = 1'b0;
        wait_idle("pre_idle");
        check("pre_q_empty", exp_q.size(), 0);
        check("pre_resp_done", rd_cnt - rd0, 1);
        check("pre_cfg_done", cd_cnt - cd0, 1);

        // tog_clr coincident with a data NEXT leaves DATA0
        exp_q.push_back(4'b1101);
        data_req = 1'b1;
        wait_busy("tc_start");
        data_req = 1'b0;
        i = 0;
        while (!data_done && i < 100) begin @(negedge clk); i++; end
        check("tc_done_seen", data_done, 1);
        tog_clr = 1'b1;
        @(negedge clk);
        tog_clr = 1'b0;
        wait_idle("tc_idle");
        exp_q.push_back(4'b1101);
        run_data();
        check("tc_q_empty", exp_q.size(), 0);

        // Timeout: fs held TMO cycles, err pulse, response retried
        rd0 = rd_cnt; e0 = err_cnt;
        fd_hang = 1'b1;
        exp_q.push_back(4'b0011);
        pulse_resp(2'b11);
        i = 0;
        while (!tx_fs && i < 50) begin @(negedge clk); i++; end
        n = 0;
        while (tx_fs && n < 100) begin n++; @(negedge clk); end
        check("tmo_fs_cycles", n, TMO);
        check("tmo_err", err, 1);
        check("tmo_no_done", rd_cnt - rd0, 0);
        fd_hang = 1'b0;
        exp_q.push_back(4'b0011);
        wait_busy("tmo_retry_start");
        wait_idle("tmo_retry_end");
        check("tmo_retry_done", rd_cnt - rd0, 1);
        check("tmo_err_count", err_cnt - e0, 1);

        // Reset during SEND drops fs without a clock edge and clears pending
        fd_hang = 1'b1;
        exp_q.push_back(4'b0001);
        pulse_resp(2'b01);
        i = 0;
        while (!tx_fs && i < 50) begin @(negedge clk); i++; end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rsend_fs", tx_fs, 0);
        check("rsend_busy", busy, 0);
        check("rsend_btype", tx_btype, 0);
        @(negedge clk);
        fd_hang = 1'b0;
        rst = 1'b1;
        busy_seen = 1'b0;
        repeat (6) begin @(negedge clk); busy_seen |= busy; end
        check("rsend_pend_cleared", busy_seen, 0);

        // Reset during HOLD, then arbitration on the first edge after release
        exp_q.push_back(4'b1101);
        run_data();
        exp_q.push_back(4'b1110);
        fd_stick = 1'b1;
        data_req = 1'b1;
        wait_busy("rhold_start");
        data_req = 1'b0;
        i = 0;
        while (!(busy && !tx_fs && tx_fd) && i < 50) begin @(negedge clk); i++; end
        check("rhold_reached", {busy, tx_fs, tx_fd}, 3'b101);
        rst = 1'b0;
        #1;
        check("rhold_fs", tx_fs, 0);
        check("rhold_busy", busy, 0);
        check("rhold_btype", tx_btype, 0);
        fd_stick = 1'b0;
        data_req = 1'b1;
        exp_q.push_back(4'b1101);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rel_busy", busy, 1);
        check("rel_btype_data0", tx_btype, 4'b1101);
        data_req = 1'b0;
        wait_idle("rel_idle");
        check("final_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
